// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: run/stop/clear FSM, tick prescaler and the
// msec/sec/min/hour counter chain feeding the FND display controller.
module stopwatch_cu #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_sel,
  output logic       o_run
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PRE_W-1:0] prescaler;
  logic             tick;
  logic             msec_wrap;
  logic             sec_wrap;
  logic             min_wrap;
  logic             hour_wrap;

  // Clear has priority over run when both arrive while stopped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: begin
        if (i_btn_clear)    state_nxt = ST_CLEAR;
        else if (i_btn_run) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_btn_run) state_nxt = ST_STOP;
      end
      ST_CLEAR: state_nxt = ST_STOP;
      default:  state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_STOP;
    else     state <= state_nxt;
  end

  assign o_run = (state == ST_RUN);

  // Prescaler holds in STOP so a resume keeps the sub-tick fraction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (state == ST_CLEAR) begin
      prescaler <= '0;
    end else if (state == ST_RUN) begin
      if (prescaler == PRE_MAX) prescaler <= '0;
      else                      prescaler <= prescaler + 1'b1;
    end
  end

  assign tick      = (state == ST_RUN) && (prescaler == PRE_MAX);
  assign msec_wrap = (o_msec == 7'd99);
  assign sec_wrap  = (o_sec  == 6'd59);
  assign min_wrap  = (o_min  == 6'd59);
  assign hour_wrap = (o_hour == 5'd23);

  // Carries ripple combinationally so all fields update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_msec <= '0;
      o_sec  <= '0;
      o_min  <= '0;
      o_hour <= '0;
    end else if (state == ST_CLEAR) begin
      o_msec <= '0;
      o_sec  <= '0;
      o_min  <= '0;
      o_hour <= '0;
    end else if (tick) begin
      o_msec <= msec_wrap ? '0 : o_msec + 7'd1;
      if (msec_wrap) begin
        o_sec <= sec_wrap ? '0 : o_sec + 6'd1;
        if (sec_wrap) begin
          o_min <= min_wrap ? '0 : o_min + 6'd1;
          if (min_wrap) begin
            o_hour <= hour_wrap ? '0 : o_hour + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             o_sel <= 1'b0;
    else if (i_btn_mode) o_sel <= ~o_sel;
  end

endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed bench for stopwatch_cu with TICK_DIV = 10.
module tb_stopwatch_cu;

  logic       clk;
  logic       rst;
  logic       btn_run;
  logic       btn_clear;
  logic       btn_mode;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       sel;
  logic       run;

  int checks = 0;
  int errors = 0;

  stopwatch_cu #(
    .CLK_FREQ(1000),
    .TICK_HZ (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn_run  (btn_run),
    .i_btn_clear(btn_clear),
    .i_btn_mode (btn_mode),
    .o_msec     (msec),
    .o_sec      (sec),
    .o_min      (min),
    .o_hour     (hour),
    .o_sel      (sel),
    .o_run      (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic b_run;
    logic b_clr;
    logic b_mode;
    int   cycles;
    int   e_run;
    int   e_sel;
    int   e_msec;
    int   e_sec;
    int   e_min;
    int   e_hour;
  } vec_t;

  vec_t vtab[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int e_run, input int e_sel, input int e_msec,
                         input int e_sec, input int e_min, input int e_hour);
    if (e_run  >= 0) chk({tag, ".run"},  32'(run),  32'(e_run));
    if (e_sel  >= 0) chk({tag, ".sel"},  32'(sel),  32'(e_sel));
    if (e_msec >= 0) chk({tag, ".msec"}, 32'(msec), 32'(e_msec));
    if (e_sec  >= 0) chk({tag, ".sec"},  32'(sec),  32'(e_sec));
    if (e_min  >= 0) chk({tag, ".min"},  32'(min),  32'(e_min));
    if (e_hour >= 0) chk({tag, ".hour"}, 32'(hour), 32'(e_hour));
  endtask

  // Inputs are held for exactly one rising edge, then n-1 idle edges follow.
  task automatic step(input logic r, input logic c, input logic m, input int n);
    btn_run   = r;
    btn_clear = c;
    btn_mode  = m;
    @(posedge clk);
    #1;
    btn_run   = 1'b0;
    btn_clear = 1'b0;
    btn_mode  = 1'b0;
    repeat (n - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic preload(input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s,
                         input logic [6:0] ms);
    force dut.o_hour = h;
    force dut.o_min  = mi;
    force dut.o_sec  = s;
    force dut.o_msec = ms;
    #1;
    release dut.o_hour;
    release dut.o_min;
    release dut.o_sec;
    release dut.o_msec;
    #1;
  endtask

  initial begin
    //               run clr mode cyc  run sel msec sec min hour
    vtab[0]  = '{1'b1, 1'b0, 1'b0,  1,  1, 0,  0, 0, 0, 0};
    vtab[1]  = '{1'b0, 1'b0, 1'b0,  9,  1, 0,  0, 0, 0, 0};
    vtab[2]  = '{1'b0, 1'b0, 1'b0,  1,  1, 0,  1, 0, 0, 0};
    vtab[3]  = '{1'b0, 1'b0, 1'b0, 40,  1, 0,  5, 0, 0, 0};
    vtab[4]  = '{1'b0, 1'b0, 1'b1,  1,  1, 1,  5, 0, 0, 0};
    vtab[5]  = '{1'b0, 1'b1, 1'b0,  1,  1, 1,  5, 0, 0, 0};
    vtab[6]  = '{1'b1, 1'b0, 1'b0,  3,  0, 1,  5, 0, 0, 0};
    vtab[7]  = '{1'b0, 1'b0, 1'b1,  1,  0, 0,  5, 0, 0, 0};
    vtab[8]  = '{1'b1, 1'b0, 1'b0,  1,  1, 0,  5, 0, 0, 0};
    vtab[9]  = '{1'b0, 1'b0, 1'b0,  6,  1, 0,  5, 0, 0, 0};
    vtab[10] = '{1'b0, 1'b0, 1'b0,  1,  1, 0,  6, 0, 0, 0};
    vtab[11] = '{1'b1, 1'b0, 1'b0,  1,  0, 0,  6, 0, 0, 0};
    vtab[12] = '{1'b1, 1'b1, 1'b1,  1,  0, 1, -1, -1, -1, -1};
    vtab[13] = '{1'b1, 1'b0, 1'b1,  1,  0, 0,  0, 0, 0, 0};
    vtab[14] = '{1'b0, 1'b0, 1'b0,  1,  0, 0,  0, 0, 0, 0};
    vtab[15] = '{1'b1, 1'b0, 1'b0,  1,  1, 0,  0, 0, 0, 0};
    vtab[16] = '{1'b0, 1'b0, 1'b0,  9,  1, 0,  0, 0, 0, 0};
    vtab[17] = '{1'b0, 1'b0, 1'b0,  1,  1, 0,  1, 0, 0, 0};

    rst       = 1'b1;
    btn_run   = 1'b0;
    btn_clear = 1'b0;
    btn_mode  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 3);
    chk_all("post_reset_idle", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      step(vtab[i].b_run, vtab[i].b_clr, vtab[i].b_mode, vtab[i].cycles);
      chk_all($sformatf("vec%0d", i), vtab[i].e_run, vtab[i].e_sel, vtab[i].e_msec,
              vtab[i].e_sec, vtab[i].e_min, vtab[i].e_hour);
    end

    // Stop at msec=37 with a partial prescaler count, hold, then resume.
    step(1'b0, 1'b0, 1'b0, 360);
    chk_all("to37", 1, 0, 37, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 4);
    step(1'b1, 1'b0, 1'b0, 1);
    chk_all("stop37", 0, 0, 37, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 200);
    chk_all("frozen", 0, 0, 37, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1);
    chk_all("resume", 1, 0, 37, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 4);
    chk_all("resume_pre", 1, 0, 37, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1);
    chk_all("resume_tick", 1, 0, 38, 0, 0, 0);

    // Rollover into minutes from 00:00:59.99.
    step(1'b1, 1'b0, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 2);
    chk_all("cleared", 0, 0, 0, 0, 0, 0);
    preload(5'd0, 6'd0, 6'd59, 7'd99);
    step(1'b1, 1'b0, 1'b0, 10);
    chk_all("pre_sec_roll", 1, 0, 99, 59, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1);
    chk_all("sec_roll", 1, 0, 0, 0, 1, 0);

    // Full rollover from 23:59:59.99.
    step(1'b1, 1'b0, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0, 2);
    preload(5'd23, 6'd59, 6'd59, 7'd99);
    step(1'b1, 1'b0, 1'b0, 10);
    chk_all("pre_full_roll", 1, 0, 99, 59, 59, 23);
    step(1'b0, 1'b0, 1'b0, 1);
    chk_all("full_roll", 1, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges while running.
    step(1'b0, 1'b0, 1'b1, 25);
    chk_all("pre_async", 1, 1, 2, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 20);
    chk_all("after_rst", 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 10);
    chk_all("rst_resume", 1, 0, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
